// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: sequencer for one fully-connected layer.
// Streams the input vector and neuron-major weights into a shared MAC,
// clears the accumulator between neurons, then saturates the Q8.8 sum,
// optionally applies ReLU, and presents it on a valid/ready result port.
module fc_layer_ctrl #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int RELU  = 1,
  parameter int X_AW  = $clog2(N_IN),
  parameter int W_AW  = $clog2(N_IN * N_OUT),
  parameter int O_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [X_AW-1:0]          x_addr,
  output logic [W_AW-1:0]          w_addr,
  output logic                     mac_valid,
  output logic                     mac_clr,
  input  logic signed [39:0]       mac_dout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [O_W-1:0]           res_idx,
  output logic signed [15:0]       res_data,
  output logic [2:0]               dbg_state_o
);

  // Result handshake: a result transfers on a rising edge where res_valid
  // and res_ready are both 1. Once raised, res_valid, res_idx and res_data
  // hold steady until that transfer; res_ready may toggle freely and has
  // no combinational path to any output.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [X_AW-1:0] I_LAST = X_AW'(N_IN - 1);
  localparam logic [O_W-1:0]  N_LAST = O_W'(N_OUT - 1);

  state_e          state_q, state_d;
  logic [X_AW-1:0] i_q, i_d;
  logic [W_AW-1:0] w_q, w_d;
  logic [O_W-1:0]  n_q, n_d;
  logic            mac_valid_q;

  logic last_in;
  logic last_out;
  logic res_fire;

  assign last_in  = (i_q == I_LAST);
  assign last_out = (n_q == N_LAST);
  assign res_fire = (state_q == S_OUT) && res_ready;

  // State register; reset from any state returns straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (last_in) state_d = S_WAIT;
      S_WAIT:  state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = last_out ? S_DONE : S_CLEAR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter next values; w keeps running across neurons so the weight
  // memory is walked neuron-major without a multiply.
  always_comb begin
    i_d = i_q;
    w_d = w_q;
    n_d = n_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d = '0;
          n_d = '0;
        end
      end
      S_CLEAR: i_d = '0;
      S_RUN: begin
        i_d = last_in ? '0 : i_q + X_AW'(1);
        w_d = w_q + W_AW'(1);
      end
      S_OUT: begin
        if (res_fire && !last_out) n_d = n_q + O_W'(1);
      end
      default: ;
    endcase
  end

  // Counters plus the one-cycle delay that aligns mac_valid with read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q         <= '0;
      w_q         <= '0;
      n_q         <= '0;
      mac_valid_q <= 1'b0;
    end else begin
      i_q         <= i_d;
      w_q         <= w_d;
      n_q         <= n_d;
      mac_valid_q <= (state_q == S_RUN);
    end
  end

  // Outputs decoded from state; result saturated from the stable accumulator.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    rd_en     = (state_q == S_RUN);
    mac_clr   = (state_q == S_CLEAR);
    mac_valid = mac_valid_q;
    res_valid = (state_q == S_OUT);
    x_addr    = i_q;
    w_addr    = w_q;
    res_idx   = '0;
    res_data  = '0;
    if (state_q == S_OUT) begin
      res_idx = n_q;
      if ((RELU != 0) && mac_dout[39]) begin
        res_data = '0;
      end else if (mac_dout > 40'sd32767) begin
        res_data = 16'h7FFF;
      end else if (mac_dout < -40'sd32768) begin
        res_data = 16'h8000;
      end else begin
        res_data = mac_dout[15:0];
      end
    end
  end

  assign dbg_state_o = state_q;

endmodule
